// File: rtl/dac_hpf_pkg.sv
// Shared types, fixed-point constants and saturation helpers for the
// time-multiplexed DAC high-pass filter engine.
package dac_hpf_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_DIFF,
        ST_WAIT,
        ST_ACC
    } state_t;

    localparam int SAMPLE_W = 16;
    localparam int STATE_W  = 32;
    localparam int FRAC_W   = 16;
    localparam int A_SHIFT  = 2;
    localparam int B_SHIFT  = 1;
    localparam int P_LSB    = 3;

    // Clamp a 17-bit intermediate to the signed 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > 17'sd32767)       r = 16'sh7fff;
        else if (v < -17'sd32768) r = 16'sh8000;
        else                      r = v[SAMPLE_W-1:0];
        return r;
    endfunction

    // Clamp a 33-bit intermediate to the signed Q16.16 state range.
    function automatic logic signed [STATE_W-1:0] sat32(input logic signed [STATE_W:0] v);
        logic signed [STATE_W-1:0] r;
        if (v > 33'sd2147483647)       r = 32'sh7fff_ffff;
        else if (v < -33'sd2147483648) r = 32'sh8000_0000;
        else                           r = v[STATE_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/dac_hpf_channel_engine_if.sv
// Sample handshake, result strobe and shared-multiplier bus of the HPF engine.
// master = the surrounding datapath (sample selector, formatter, multiplier),
// slave  = the filter engine.
interface dac_hpf_channel_engine_if #(
    parameter int CH_W = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [CH_W-1:0]        in_ch;
    logic signed [15:0]     in_data;
    logic                   hpf_en;
    logic [15:0]            hpf_coef;
    logic                   state_clear;
    logic [17:0]            mult_a;
    logic [17:0]            mult_b;
    logic [35:0]            mult_p;
    logic                   out_valid;
    logic [CH_W-1:0]        out_ch;
    logic signed [15:0]     out_data;

    modport master (
        output in_valid, in_ch, in_data, hpf_en, hpf_coef, state_clear, mult_p,
        input  in_ready, mult_a, mult_b, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, hpf_en, hpf_coef, state_clear, mult_p,
        output in_ready, mult_a, mult_b, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/dac_hpf_state_ram.sv
// Per-channel Q16.16 low-pass state store: single port, registered read,
// read-before-write. Addresses at or beyond N_CH are ignored and read as zero.
module dac_hpf_state_ram #(
    parameter int N_CH = 8,
    parameter int CH_W = 3
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [CH_W-1:0]          addr,
    input  logic signed [31:0]       wdata,
    output logic signed [31:0]       rdata
);
    logic signed [31:0] mem [N_CH];
    logic               addr_ok;

    assign addr_ok = (32'(addr) < N_CH);

    // Synchronous write and registered read of the addressed channel.
    always_ff @(posedge clk) begin
        if (we && addr_ok) mem[addr] <= wdata;
        rdata <= addr_ok ? mem[addr] : '0;
    end
endmodule

// File: rtl/dac_hpf_channel_engine.sv
// First-order IIR high-pass filter shared by N_CH DAC channels. Each accepted
// sample forms diff = x - lp_hi, sends (diff, coef) to the external multiplier,
// then outputs diff and advances lp by diff*coef.
module dac_hpf_channel_engine
    import dac_hpf_pkg::*;
#(
    parameter int N_CH         = 8,
    parameter int CH_W         = 3,
    parameter int MULT_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    dac_hpf_channel_engine_if.slave  bus
);
    state_t                     state;
    logic                       clr_pend;
    logic [CH_W-1:0]            clr_cnt;
    logic [2:0]                 wait_cnt;

    logic [CH_W-1:0]            ch_p0;
    logic signed [15:0]         x_p0;
    logic                       en_p0;
    logic [15:0]                coef_p0;
    logic signed [15:0]         diff_p1;
    logic signed [31:0]         st_p1;

    logic                       ram_we;
    logic [CH_W-1:0]            ram_addr;
    logic signed [31:0]         ram_wdata;
    logic signed [31:0]         ram_rdata;

    logic                       ch_ok;
    logic signed [15:0]         diff_w;
    logic signed [31:0]         prod_w;
    logic signed [31:0]         acc_w;
    logic                       unused_p;

    assign ch_ok    = ({1'b0, ch_p0} < (CH_W+1)'(N_CH));
    assign diff_w   = sat16($signed({x_p0[15], x_p0}) - $signed({ram_rdata[31], ram_rdata[31:16]}));
    assign prod_w   = $signed(bus.mult_p[34:P_LSB]);
    assign acc_w    = sat32($signed({st_p1[31], st_p1}) + $signed({prod_w[31], prod_w}));
    assign unused_p = ^{bus.mult_p[35], bus.mult_p[P_LSB-1:0]};

    dac_hpf_state_ram #(.N_CH(N_CH), .CH_W(CH_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State RAM port steering: sweep in CLEAR, prefetch in IDLE, write-back in ACC.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ch_p0;
        ram_wdata = '0;
        case (state)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt;
            end
            ST_IDLE: ram_addr = bus.in_ch;
            ST_ACC: begin
                ram_we    = ch_ok;
                ram_wdata = en_p0 ? acc_w : {x_p0, 16'h0000};
            end
            default: ;
        endcase
    end

    // Sample capture at accept, then difference and old state at the DIFF edge.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.in_valid) begin
            ch_p0   <= bus.in_ch;
            x_p0    <= bus.in_data;
            en_p0   <= bus.hpf_en;
            coef_p0 <= bus.hpf_coef;
        end
        if (state == ST_DIFF) begin
            diff_p1 <= diff_w;
            st_p1   <= ram_rdata;
        end
    end

    // Control FSM with registered handshake, multiplier operands and result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            clr_pend     <= 1'b1;
            clr_cnt      <= '0;
            wait_cnt     <= '0;
            bus.in_ready <= 1'b1;
            bus.out_valid<= 1'b0;
            bus.out_ch   <= '0;
            bus.out_data <= '0;
            bus.mult_a   <= '0;
            bus.mult_b   <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.state_clear && state != ST_IDLE && state != ST_CLEAR) clr_pend <= 1'b1;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CH_W'(N_CH-1)) begin
                        state        <= ST_IDLE;
                        bus.in_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_pend || bus.state_clear) begin
                        state        <= ST_CLEAR;
                        clr_pend     <= 1'b0;
                        clr_cnt      <= '0;
                        bus.in_ready <= 1'b0;
                    end else if (bus.in_valid) begin
                        state        <= ST_DIFF;
                        bus.in_ready <= 1'b0;
                    end
                end
                ST_DIFF: begin
                    bus.mult_a <= {diff_w, 2'b00};
                    bus.mult_b <= {1'b0, coef_p0, 1'b0};
                    wait_cnt   <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'(MULT_LATENCY-1)) state <= ST_ACC;
                    else wait_cnt <= wait_cnt + 1'b1;
                end
                ST_ACC: begin
                    bus.out_valid <= 1'b1;
                    bus.out_ch    <= ch_p0;
                    bus.out_data  <= (en_p0 && ch_ok) ? diff_p1 : x_p0;
                    if (clr_pend || bus.state_clear) begin
                        state    <= ST_CLEAR;
                        clr_pend <= 1'b0;
                        clr_cnt  <= '0;
                    end else begin
                        state        <= ST_IDLE;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_hpf_channel_engine.sv
// Bench for dac_hpf_channel_engine: directed vector table with hand-derived
// results, multi-cycle clear/reset sequences, and random samples against an
// arithmetic model of the filter.
module tb_dac_hpf_channel_engine;
    localparam int N_CH         = 6;
    localparam int CH_W         = 3;
    localparam int MULT_LATENCY = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    longint lp [8];

    always #5 clk = ~clk;

    dac_hpf_channel_engine_if #(.CH_W(CH_W)) bus ();

    dac_hpf_channel_engine #(.N_CH(N_CH), .CH_W(CH_W), .MULT_LATENCY(MULT_LATENCY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // External registered 18x18 multiplier.
    logic signed [35:0] mpipe [MULT_LATENCY];
    always @(posedge clk) begin
        mpipe[0] <= $signed(bus.mult_a) * $signed(bus.mult_b);
        for (int i = 1; i < MULT_LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mult_p = mpipe[MULT_LATENCY-1];

    typedef struct {
        int ch;
        int x;
        bit en;
        int coef;
        int exp;
    } vec_t;
    vec_t tbl [19];

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Filter rule: y = sat(x - floor(lp)), lp += y*coef/65536 (lp kept in 1/65536 units).
    function automatic int model_step(input int ch, input int x, input bit en, input int coef);
        longint d;
        if (ch >= N_CH) return x;
        if (!en) begin
            lp[ch] = longint'(x) * 65536;
            return x;
        end
        d = clamp(longint'(x) - (lp[ch] >>> 16), -32768, 32767);
        lp[ch] = clamp(lp[ch] + d * longint'(coef), -64'sd2147483648, 64'sd2147483647);
        return int'(d);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) lp[i] = 0;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic accept(input int ch, input int x, input bit en, input int coef);
        int n = 0;
        while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
        chk("in_ready_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_ch    = ch[CH_W-1:0];
        bus.in_data  = x[15:0];
        bus.hpf_en   = en;
        bus.hpf_coef = coef[15:0];
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int ch, input int exp, input int start, input string name);
        int cyc = start;
        while (!bus.out_valid && cyc < 60) begin @(negedge clk); cyc++; end
        chk({name, "_latency"}, cyc, 3 + MULT_LATENCY);
        chk({name, "_ch"}, bus.out_ch, ch & 7);
        chk({name, "_data"}, bus.out_data, exp);
        @(negedge clk);
        chk({name, "_strobe"}, bus.out_valid, 0);
    endtask

    task automatic run_sample(input int ch, input int x, input bit en, input int coef,
                              input int exp, input string name);
        accept(ch, x, en, coef);
        collect(ch, exp, 1, name);
    endtask

    task automatic do_reset(input string name);
        int cnt = 0;
        bit seen = 1'b0;
        bus.in_valid = 1'b0;
        bus.state_clear = 1'b0;
        reset_n = 1'b0;
        repeat (2) begin @(negedge clk); seen |= bus.out_valid; end
        chk({name, "_rst_in_ready"}, bus.in_ready, 1);
        chk({name, "_rst_out_valid"}, bus.out_valid, 0);
        chk({name, "_rst_out_ch"}, bus.out_ch, 0);
        chk({name, "_rst_out_data"}, bus.out_data, 0);
        chk({name, "_rst_mult_a"}, bus.mult_a, 0);
        chk({name, "_rst_mult_b"}, bus.mult_b, 0);
        reset_n = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && cnt < 100) begin seen |= bus.out_valid; cnt++; @(negedge clk); end
        chk({name, "_clear_ready_low"}, cnt, N_CH);
        chk({name, "_no_out_valid"}, seen, 0);
        model_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int exp;
        int cnt;
        bit seen;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0;
        bus.hpf_en = 1'b0; bus.hpf_coef = '0; bus.state_clear = 1'b0;

        tbl[0]  = '{0,  1000,   1, 0,     1000};
        tbl[1]  = '{0,  1000,   1, 0,     1000};
        tbl[2]  = '{0,  1000,   1, 0,     1000};
        tbl[3]  = '{0,  1000,   1, 32768, 1000};
        tbl[4]  = '{0,  1000,   1, 32768, 500};
        tbl[5]  = '{0,  1000,   1, 32768, 250};
        tbl[6]  = '{0,  875,    1, 0,     0};
        tbl[7]  = '{2,  1000,   1, 32768, 1000};
        tbl[8]  = '{3,  -2000,  1, 32768, -2000};
        tbl[9]  = '{2,  1000,   1, 32768, 500};
        tbl[10] = '{3,  -2000,  1, 32768, -1000};
        tbl[11] = '{1,  -32768, 0, 0,     -32768};
        tbl[12] = '{1,  32767,  1, 65535, 32767};
        tbl[13] = '{1,  0,      1, 0,     2};
        tbl[14] = '{4,  700,    0, 0,     700};
        tbl[15] = '{4,  700,    1, 32768, 0};
        tbl[16] = '{7,  1234,   1, 32768, 1234};
        tbl[17] = '{7,  1234,   1, 32768, 1234};
        tbl[18] = '{6,  -5,     0, 0,     -5};

        do_reset("init");

        for (int i = 0; i < 19; i++) begin
            void'(model_step(tbl[i].ch, tbl[i].x, tbl[i].en, tbl[i].coef));
            run_sample(tbl[i].ch, tbl[i].x, tbl[i].en, tbl[i].coef, tbl[i].exp,
                       $sformatf("vec%0d", i));
        end

        // state_clear while the sample waits on the multiplier
        exp = model_step(2, 1000, 1, 32768);
        accept(2, 1000, 1, 32768);
        @(negedge clk); bus.state_clear = 1'b1;
        @(negedge clk); bus.state_clear = 1'b0;
        collect(2, exp, 3, "clrwait");
        model_clear();
        cnt = 0;
        while (!bus.in_ready && cnt < 100) begin cnt++; @(negedge clk); end
        chk("clrwait_ready_low", cnt, N_CH - 1);
        run_sample(2, 1000, 1, 32768, model_step(2, 1000, 1, 32768), "clrwait_ch2");
        run_sample(0, -7, 1, 0, model_step(0, -7, 1, 0), "clrwait_ch0");

        // state_clear in IDLE wins over a simultaneous sample
        void'(model_step(3, -2000, 1, 32768));
        bus.state_clear = 1'b1;
        bus.in_valid = 1'b1; bus.in_ch = 3'd3; bus.in_data = 16'sd50; bus.hpf_en = 1'b1;
        @(negedge clk);
        bus.state_clear = 1'b0; bus.in_valid = 1'b0;
        model_clear();
        cnt = 0; seen = 1'b0;
        while (!bus.in_ready && cnt < 100) begin seen |= bus.out_valid; cnt++; @(negedge clk); end
        repeat (6) begin seen |= bus.out_valid; @(negedge clk); end
        chk("idleclr_ready_low", cnt, N_CH);
        chk("idleclr_dropped", seen, 0);
        run_sample(3, -2000, 1, 32768, model_step(3, -2000, 1, 32768), "idleclr_ch3");

        // reset while the sample waits on the multiplier
        run_sample(5, 3000, 0, 0, model_step(5, 3000, 0, 0), "ch5_load");
        accept(5, 3000, 1, 32768);
        @(negedge clk);
        do_reset("midwait");
        run_sample(5, 3000, 1, 0, model_step(5, 3000, 1, 0), "midwait_ch5");

        // random samples against the model
        for (int i = 0; i < 80; i++) begin
            int ch, x, coef, r;
            bit en;
            ch = $urandom_range(0, 7);
            r  = $urandom_range(0, 7);
            x  = (r == 0) ? 32767 : ((r == 1) ? -32768 : int'($urandom_range(0, 65535)) - 32768);
            en = ($urandom_range(0, 4) != 0);
            coef = ($urandom_range(0, 5) == 0) ? 65535 : $urandom_range(0, 65535);
            exp = model_step(ch, x, en, coef);
            run_sample(ch, x, en, coef, exp, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
